sram_arbiter_2p: RTL
====================

// Module: sram_arbiter_2p
// PURPOSE
//  Shares one 512x32 single-port synchronous SRAM (sram512X32) between two requesters, e.g. CPU-side port 0 and DMA/camera port 1.
//  Does one access per clock and uses a round-robin arbiter with a burst limit.
//  Returns registered read data one cycle after the grant. Optional post-reset memory clear.
// PARAMETERS
//  MAX_BURST  8   max consecutive grants to the current owner while the other port is requesting (1..255)
// PORTS
//  clock      in   1   system clock; all state updates on rising edge
//  nReset     in   1   synchronous, active-low reset
//  cX_req     in   1   port X (X=0,1) access request; held until granted
//  cX_we      in   1   1=write, 0=read; qualified by cX_req
//  cX_addr    in   9   word address
//  cX_wdata   in   32  write data
//  cX_grant   out  1   access issued to SRAM this cycle (combinational)
//  cX_rvalid  out  1   cX_rdata valid; pulses 1 cycle after a granted read
//  cX_rdata   out  32  read data (SRAM dataOut, shared by both ports)
//  busy       out  1   arbiter not accepting requests (clear in progress)
// BEHAVIOUR
//  Reset: nReset low at an edge -> state IDLE (CLEAR if macro), burstCnt=0, lastWin=1, cX_rvalid=0.
//   cX_grant=0 whenever nReset=0. busy=0 (1 if macro). SRAM contents are not reset.
//  FSM states IDLE, OWN0, OWN1 (+CLEAR):
//   IDLE: only c0_req -> grant 0, go OWN0. Only c1_req -> grant 1, go OWN1.
//    Both requesting -> grant ~lastWin. None requesting -> stay.
//   OWNx: cx_req=1 and (burstCnt<MAX_BURST or other port idle) -> grant x, stay.
//   OWNx: cx_req=0 or (burstCnt==MAX_BURST and other port requesting) -> grant the other port if it requests, else IDLE.
//   Every state change to OWNy in the same cycle as a grant loads burstCnt=1 and lastWin=y.
//   A grant while staying in OWNx increments burstCnt, saturating at MAX_BURST.
//  At most one cX_grant per cycle; grants are mutually exclusive.
//  SRAM drive: address=winner addr, dataIn=winner wdata, writeEnable=grant & winner we.
//  Read latency is 1: cX_rvalid <= cX_grant & ~cX_we. cX_rdata is valid only while cX_rvalid=1.
//  Write followed next cycle by a read of the same address returns the new data.
//  Read and write to the same address in one cycle cannot occur (single grant).
//  Back-to-back grants every cycle are allowed; throughput is 1 access/cycle total.
//  Address wraps are not handled: 9-bit address only, no wrap logic.
//  Reset mid-operation: a read granted in the reset cycle gets no rvalid, and its pending rvalid is dropped.
//   A write granted in the reset cycle is not performed, because grant is forced 0.
// CONFIGURATION
//  SRAM_ARB_CLEAR_EN defined:
//   After reset, state CLEAR: write 0 to addresses 0..511, one per cycle, via a 9-bit clrAddr counter; busy=1, no grants.
//   Enter IDLE in the cycle after address 511 is written, i.e. 512 busy cycles; busy=0 from then on.
//   nReset during CLEAR restarts the clear at 0.
//  Undefined: no CLEAR state or counter; busy tied 0; reset goes straight to IDLE.
// STRUCTURE
//  Package sram_arb_pkg:
//   state encoding localparams (ST_IDLE, ST_OWN0, ST_OWN1, ST_CLEAR)
//   SRAM_AW=9, SRAM_DW=32, SRAM_DEPTH=512
//  Sub-module: one instance of sram512X32. Arbiter FSM, burst counter and rvalid pipeline stay inline.
// TESTING
//  1 Single port, no macro:
//    c0 write 0x005<-0xDEADBEEF, then c0 read 0x005 -> c0_grant both cycles; c0_rvalid 1 cycle after the read grant, c0_rdata=0xDEADBEEF.
//  2 Contention from IDLE after reset, c0 and c1 both requesting -> c0 granted first (lastWin=1).
//  3 Burst limit: c0 and c1 requesting continuously, MAX_BURST=8 -> grant pattern c0 x8, c1 x8, c0 x8.
//    No idle cycle at any switch.
//  4 Owner drops req: c0 owns with burstCnt=3 and deasserts req, c1 requesting -> c1 granted that same cycle, burstCnt=1.
//  5 Reset mid-read: c1 read granted, nReset=0 next edge -> c1_rvalid stays 0, state IDLE, no grants while nReset=0.
//  6 SRAM_ARB_CLEAR_EN: preload 0x1FF=0x12345678, reset -> busy=1 for 512 cycles with requests ignored;
//    then c0 reads of 0x000 and 0x1FF return 0.

Source files
------------

// File: rtl/sram_arbiter_2p_pkg.sv
// Shared constants and FSM state type for the two-port SRAM arbiter.
// Imported by the interface, the SRAM model and the arbiter top.
package sram_arb_pkg;

   localparam int SRAM_AW    = 9;
   localparam int SRAM_DW    = 32;
   localparam int SRAM_DEPTH = 512;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN0  = 2'd1,
      ST_OWN1  = 2'd2,
      ST_CLEAR = 2'd3
   } arb_state_e;

endpackage

// File: rtl/sram_arbiter_2p_if.sv
// Request/grant/read-data bundle for both requester ports plus the busy flag.
// The requester side is the master modport; the arbiter uses the slave modport.
interface sram_arbiter_2p_if;
   import sram_arb_pkg::*;

   logic               c0_req;
   logic               c0_we;
   logic [SRAM_AW-1:0] c0_addr;
   logic [SRAM_DW-1:0] c0_wdata;
   logic               c0_grant;
   logic               c0_rvalid;
   logic [SRAM_DW-1:0] c0_rdata;

   logic               c1_req;
   logic               c1_we;
   logic [SRAM_AW-1:0] c1_addr;
   logic [SRAM_DW-1:0] c1_wdata;
   logic               c1_grant;
   logic               c1_rvalid;
   logic [SRAM_DW-1:0] c1_rdata;

   logic               busy;

   modport master (
      output c0_req, c0_we, c0_addr, c0_wdata,
      output c1_req, c1_we, c1_addr, c1_wdata,
      input  c0_grant, c0_rvalid, c0_rdata,
      input  c1_grant, c1_rvalid, c1_rdata,
      input  busy
   );

   modport slave (
      input  c0_req, c0_we, c0_addr, c0_wdata,
      input  c1_req, c1_we, c1_addr, c1_wdata,
      output c0_grant, c0_rvalid, c0_rdata,
      output c1_grant, c1_rvalid, c1_rdata,
      output busy
   );

endinterface

// File: rtl/sram_arbiter_2p_sram.sv
// Behavioural 512x32 single-port synchronous SRAM (sram512X32).
// Read data is registered; a write cycle returns the old word, which the arbiter never uses.
module sram512X32
   import sram_arb_pkg::*;
(
   input  logic               clock,
   input  logic [SRAM_AW-1:0] address,
   input  logic [SRAM_DW-1:0] dataIn,
   input  logic               writeEnable,
   output logic [SRAM_DW-1:0] dataOut
);

   logic [SRAM_DW-1:0] mem_q [SRAM_DEPTH];
   logic [SRAM_DW-1:0] rd_data_q;

   always_ff @(posedge clock) begin
      if (writeEnable) begin
         mem_q[address] <= dataIn;
      end
      rd_data_q <= mem_q[address];
   end

   assign dataOut = rd_data_q;

endmodule

// File: rtl/sram_arbiter_2p.sv
// Round-robin, burst-limited arbiter sharing one sram512X32 between two ports.
// Define SRAM_ARB_CLEAR_EN to zero the whole SRAM after every reset (busy held meanwhile).
module sram_arbiter_2p
   import sram_arb_pkg::*;
#(
   parameter int unsigned MAX_BURST = 8
)
(
   input  logic               clock,
   input  logic               nReset,
   sram_arbiter_2p_if.slave   bus
);

   localparam logic [7:0] MAX_B = 8'(MAX_BURST);

   arb_state_e         state_q, state_d;
   logic [7:0]         burst_cnt_q, burst_cnt_d;
   logic               last_win_q, last_win_d;
   logic               c0_rvalid_q, c0_rvalid_d;
   logic               c1_rvalid_q, c1_rvalid_d;
   logic               grant0, grant1;
   logic [SRAM_AW-1:0] sram_addr;
   logic [SRAM_DW-1:0] sram_din;
   logic [SRAM_DW-1:0] sram_dout;
   logic               sram_we;
`ifdef SRAM_ARB_CLEAR_EN
   logic [SRAM_AW-1:0] clr_addr_q, clr_addr_d;
`endif

   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      last_win_d  = last_win_q;
      grant0      = 1'b0;
      grant1      = 1'b0;
`ifdef SRAM_ARB_CLEAR_EN
      clr_addr_d  = clr_addr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.c0_req && (!bus.c1_req || last_win_q)) grant0 = 1'b1;
            else if (bus.c1_req)                           grant1 = 1'b1;
         end
         ST_OWN0: begin
            if (bus.c0_req && (burst_cnt_q < MAX_B || !bus.c1_req)) grant0 = 1'b1;
            else if (bus.c1_req)                                   grant1 = 1'b1;
            else                                                   state_d = ST_IDLE;
         end
         ST_OWN1: begin
            if (bus.c1_req && (burst_cnt_q < MAX_B || !bus.c0_req)) grant1 = 1'b1;
            else if (bus.c0_req)                                   grant0 = 1'b1;
            else                                                   state_d = ST_IDLE;
         end
         ST_CLEAR: begin
`ifdef SRAM_ARB_CLEAR_EN
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == '1) state_d = ST_IDLE;
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      // Reset suppresses any grant so a write issued in the reset cycle never reaches the SRAM.
      if (!nReset) begin
         grant0 = 1'b0;
         grant1 = 1'b0;
      end

      if (grant0) begin
         if (state_q == ST_OWN0) begin
            if (burst_cnt_q < MAX_B) burst_cnt_d = burst_cnt_q + 8'd1;
         end else begin
            state_d     = ST_OWN0;
            burst_cnt_d = 8'd1;
            last_win_d  = 1'b0;
         end
      end
      if (grant1) begin
         if (state_q == ST_OWN1) begin
            if (burst_cnt_q < MAX_B) burst_cnt_d = burst_cnt_q + 8'd1;
         end else begin
            state_d     = ST_OWN1;
            burst_cnt_d = 8'd1;
            last_win_d  = 1'b1;
         end
      end

      c0_rvalid_d = grant0 & ~bus.c0_we;
      c1_rvalid_d = grant1 & ~bus.c1_we;
   end

   always_comb begin
      sram_addr = grant1 ? bus.c1_addr  : bus.c0_addr;
      sram_din  = grant1 ? bus.c1_wdata : bus.c0_wdata;
      sram_we   = (grant0 & bus.c0_we) | (grant1 & bus.c1_we);
`ifdef SRAM_ARB_CLEAR_EN
      if (state_q == ST_CLEAR) begin
         sram_addr = clr_addr_q;
         sram_din  = '0;
         sram_we   = nReset;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (!nReset) begin
`ifdef SRAM_ARB_CLEAR_EN
         state_q     <= ST_CLEAR;
         clr_addr_q  <= '0;
`else
         state_q     <= ST_IDLE;
`endif
         burst_cnt_q <= '0;
         last_win_q  <= 1'b1;
         c0_rvalid_q <= 1'b0;
         c1_rvalid_q <= 1'b0;
      end else begin
`ifdef SRAM_ARB_CLEAR_EN
         clr_addr_q  <= clr_addr_d;
`endif
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         last_win_q  <= last_win_d;
         c0_rvalid_q <= c0_rvalid_d;
         c1_rvalid_q <= c1_rvalid_d;
      end
   end

   sram512X32 u_sram (
      .clock       (clock),
      .address     (sram_addr),
      .dataIn      (sram_din),
      .writeEnable (sram_we),
      .dataOut     (sram_dout)
   );

   assign bus.c0_grant  = grant0;
   assign bus.c1_grant  = grant1;
   assign bus.c0_rvalid = c0_rvalid_q;
   assign bus.c1_rvalid = c1_rvalid_q;
   assign bus.c0_rdata  = sram_dout;
   assign bus.c1_rdata  = sram_dout;
`ifdef SRAM_ARB_CLEAR_EN
   assign bus.busy      = (state_q == ST_CLEAR);
`else
   assign bus.busy      = 1'b0;
`endif

endmodule
